// File: rtl/nios2_pio_irq_in.sv
// Avalon-MM parallel input port with synchronizer, optional per-bit debounce,
// edge capture and a masked level interrupt.
module nios2_pio_irq_in #(
  parameter int DATA_WIDTH      = 10,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] sync1_r;
  logic [DATA_WIDTH-1:0] sync2_r;
  logic [DATA_WIDTH-1:0] stable_s;
  logic [DATA_WIDTH-1:0] prev_r;
  logic [DATA_WIDTH-1:0] event_s;
  logic [DATA_WIDTH-1:0] clear_s;
  logic [DATA_WIDTH-1:0] edgecap_r;
  logic [DATA_WIDTH-1:0] irqmask_r;
  logic                  wr_s;
  logic [31:0]           rd_next_s;

  assign wr_s = chipselect & ~write_n;

  // Two-flop synchronizer for the asynchronous inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_s = sync2_r;
    end else begin : g_debounce
      localparam logic [15:0] LAST_CNT = 16'(DEBOUNCE_CYCLES - 1);
      for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        logic [15:0] cnt_r;
        logic        bit_r;
        // Accept a new level only after it differs for DEBOUNCE_CYCLES straight cycles
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_r <= 16'd0;
            bit_r <= 1'b0;
          end else if (sync2_r[i] == bit_r) begin
            cnt_r <= 16'd0;
          end else if (cnt_r == LAST_CNT) begin
            cnt_r <= 16'd0;
            bit_r <= sync2_r[i];
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        assign stable_s[i] = bit_r;
      end
    end

    if (DATA_WIDTH < 32) begin : g_unused
      logic unused_wdata_s;
      assign unused_wdata_s = ^writedata[31:DATA_WIDTH];
    end
  endgenerate

  // Per-bit edge detection on the stable value
  always_comb begin
    case (EDGE_TYPE)
      32'sd0:  event_s = stable_s & ~prev_r;
      32'sd1:  event_s = ~stable_s & prev_r;
      default: event_s = stable_s ^ prev_r;
    endcase
  end

  // Read mux; upper bits stay zero when DATA_WIDTH < 32
  always_comb begin
    rd_next_s = 32'd0;
    clear_s   = '0;
    if (wr_s && (address == 2'd3)) begin
      clear_s = writedata[DATA_WIDTH-1:0];
    end else begin
      clear_s = '0;
    end
    case (address)
      2'd0:    rd_next_s[DATA_WIDTH-1:0] = stable_s;
      2'd1:    rd_next_s = 32'd0;
      2'd2:    rd_next_s[DATA_WIDTH-1:0] = irqmask_r;
      2'd3:    rd_next_s[DATA_WIDTH-1:0] = edgecap_r;
      default: rd_next_s = 32'd0;
    endcase
  end

  // Edge capture (a new event beats a clear), mask register and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r    <= '0;
      edgecap_r <= '0;
      irqmask_r <= '0;
      readdata  <= 32'd0;
    end else begin
      prev_r    <= stable_s;
      edgecap_r <= (edgecap_r & ~clear_s) | event_s;
      if (wr_s && (address == 2'd2)) begin
        irqmask_r <= writedata[DATA_WIDTH-1:0];
      end
      readdata  <= rd_next_s;
    end
  end

  assign irq = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_nios2_pio_irq_in.sv
// Scoreboard bench: four instances (rising, falling, any edge, debounced rising)
// share one bus and input; a monitor checks queued expectations per cycle.
module tb_nios2_pio_irq_in;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      address = 2'd0;
  logic            chipselect = 1'b0;
  logic            write_n = 1'b1;
  logic [31:0]     writedata = 32'd0;
  logic [9:0]      in_port = 10'd0;
  logic [3:0][31:0] rd;
  logic [3:0]      irq_v;
  logic            probe = 1'b0;
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;

  typedef struct {
    int          due;
    int          id;
    bit          is_irq;
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nios2_pio_irq_in #(.DATA_WIDTH(10), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .in_port(in_port), .irq(irq_v[0]));
  nios2_pio_irq_in #(.DATA_WIDTH(10), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .in_port(in_port), .irq(irq_v[1]));
  nios2_pio_irq_in #(.DATA_WIDTH(10), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .in_port(in_port), .irq(irq_v[2]));
  nios2_pio_irq_in #(.DATA_WIDTH(10), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[3]), .in_port(in_port), .irq(irq_v[3]));

  // due = -1 means "check at the next probe pulse" (asynchronous reset effects)
  function automatic void ex_rd(input int id, input int dly, input logic [31:0] v, input string nm);
    sb.push_back('{(dly < 0) ? -1 : cyc + dly, id, 1'b0, v, nm});
  endfunction

  function automatic void ex_irq(input int id, input int dly, input logic v, input string nm);
    sb.push_back('{(dly < 0) ? -1 : cyc + dly, id, 1'b1, {31'd0, v}, nm});
  endfunction

  function automatic void ex_irq4(input int dly, input logic b0, input logic b1,
                                  input logic b2, input logic b3, input string nm);
    ex_irq(0, dly, b0, nm);
    ex_irq(1, dly, b1, nm);
    ex_irq(2, dly, b2, nm);
    ex_irq(3, dly, b3, nm);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read4(input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3, input string nm);
    address = a;
    ex_rd(0, 1, e0, nm);
    ex_rd(1, 1, e1, nm);
    ex_rd(2, 1, e2, nm);
    ex_rd(3, 1, e3, nm);
    tick(1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  // Monitor: compare every expectation whose sample point has arrived
  initial begin
    logic [31:0] act;
    exp_t        keep[$];
    forever begin
      @(posedge clk or posedge probe);
      #1;
      keep = {};
      foreach (sb[i]) begin
        if ((probe && sb[i].due == -1) || (!probe && sb[i].due >= 0 && sb[i].due <= cyc)) begin
          act = sb[i].is_irq ? {31'd0, irq_v[sb[i].id]} : rd[sb[i].id];
          n_cmp++;
          if (sb[i].due >= 0 && sb[i].due < cyc) begin
            n_bad++;
            $display("FAIL %s dut%0d: sample missed at cycle %0d (due %0d)", sb[i].name, sb[i].id, cyc, sb[i].due);
          end else if (act !== sb[i].val) begin
            n_bad++;
            $display("FAIL %s dut%0d %s: got %h expected %h", sb[i].name, sb[i].id,
                     sb[i].is_irq ? "irq" : "readdata", act, sb[i].val);
          end
        end else begin
          keep.push_back(sb[i]);
        end
      end
      sb = keep;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    reset_n = 1'b1;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      ex_irq4(1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_irq");
      read4(2'(a), 32'd0, 32'd0, 32'd0, 32'd0, "rst_read");
    end

    // 0x000 -> 0x2A5: stable two edges later, debounced one after N more
    address = 2'd0;
    in_port = 10'h2A5;
    for (int d = 0; d < 3; d++) begin
      ex_rd(d, 2, 32'h0, "lat_before");
      ex_rd(d, 3, 32'h2A5, "lat_stable");
    end
    ex_rd(3, 6, 32'h0, "db_lat_before");
    ex_rd(3, 7, 32'h2A5, "db_lat_stable");
    tick(8);
    read4(2'd3, 32'h2A5, 32'h0, 32'h2A5, 32'h2A5, "cap_2a5");
    wr(2'd3, 32'h3FF);
    read4(2'd3, 32'h0, 32'h0, 32'h0, 32'h0, "cap_clear");

    // irq path with mask 0x001
    wr(2'd2, 32'h1);
    in_port = 10'h2A4;
    tick(8);
    wr(2'd3, 32'h3FF);
    in_port = 10'h2A5;
    ex_irq4(2, 1'b0, 1'b0, 1'b0, 1'b0, "irq_early");
    ex_irq4(3, 1'b1, 1'b0, 1'b1, 1'b0, "irq_rise");
    ex_irq(3, 6, 1'b0, "db_irq_early");
    ex_irq(3, 7, 1'b1, "db_irq_rise");
    tick(8);
    ex_irq4(2, 1'b0, 1'b0, 1'b0, 1'b0, "irq_cleared");
    wr(2'd3, 32'h1);
    tick(1);

    // Event and clear on the same edge: set wins
    in_port = 10'h2A4;
    tick(8);
    wr(2'd3, 32'h3FF);
    in_port = 10'h2A5;
    tick(2);
    wr(2'd3, 32'h1);
    tick(6);
    ex_irq4(1, 1'b1, 1'b0, 1'b1, 1'b1, "set_wins_irq");
    read4(2'd3, 32'h1, 32'h0, 32'h1, 32'h1, "set_wins");

    // Debounce: 3-cycle glitch on bit3 ignored, 6-cycle pulse accepted
    wr(2'd3, 32'h3FF);
    address = 2'd0;
    in_port = 10'h2AD;
    for (int d = 1; d <= 12; d++) ex_rd(3, d, 32'h2A5, "glitch_stable");
    tick(3);
    in_port = 10'h2A5;
    tick(10);
    read4(2'd3, 32'h8, 32'h8, 32'h8, 32'h0, "glitch_cap");
    wr(2'd3, 32'h3FF);
    address = 2'd0;
    in_port = 10'h2AD;
    ex_rd(3, 6, 32'h2A5, "pulse_before");
    ex_rd(3, 7, 32'h2AD, "pulse_stable");
    tick(6);
    in_port = 10'h2A5;
    tick(10);
    read4(2'd3, 32'h8, 32'h8, 32'h8, 32'h8, "pulse_cap");

    // Falling / any edge on bit5
    wr(2'd3, 32'h3FF);
    in_port = 10'h285;
    tick(8);
    read4(2'd3, 32'h0, 32'h20, 32'h20, 32'h0, "fall_cap");
    wr(2'd3, 32'h3FF);
    in_port = 10'h2A5;
    tick(8);
    read4(2'd3, 32'h20, 32'h0, 32'h20, 32'h20, "rise_cap");

    // Mask write width, read-during-write, ignored addresses
    for (int d = 0; d < 4; d++) ex_rd(d, 1, 32'h1, "rdw_old_mask");
    wr(2'd2, 32'hFFFF_FFFF);
    read4(2'd2, 32'h3FF, 32'h3FF, 32'h3FF, 32'h3FF, "mask_3ff");
    ex_irq4(1, 1'b1, 1'b0, 1'b1, 1'b1, "mask_irq");
    wr(2'd0, 32'h1234_5678);
    wr(2'd1, 32'hFFFF_FFFF);
    read4(2'd0, 32'h2A5, 32'h2A5, 32'h2A5, 32'h2A5, "wr0_ignored");
    read4(2'd1, 32'h0, 32'h0, 32'h0, 32'h0, "addr1_zero");
    read4(2'd2, 32'h3FF, 32'h3FF, 32'h3FF, 32'h3FF, "wr1_ignored");
    read4(2'd3, 32'h20, 32'h0, 32'h20, 32'h20, "cap_kept");

    // Build capture 0x155 then reset mid-operation
    wr(2'd3, 32'h3FF);
    in_port = 10'h000;
    tick(8);
    wr(2'd3, 32'h3FF);
    in_port = 10'h155;
    tick(8);
    ex_irq4(1, 1'b1, 1'b0, 1'b1, 1'b1, "pre_rst_irq");
    read4(2'd3, 32'h155, 32'h0, 32'h155, 32'h155, "pre_rst_cap");
    in_port = 10'h000;
    reset_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      ex_rd(d, -1, 32'h0, "async_rst_rd");
      ex_irq(d, -1, 1'b0, "async_rst_irq");
    end
    probe = 1'b1;
    #2;
    probe = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    ex_irq4(1, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_irq");
    for (int a = 0; a < 4; a++) read4(2'(a), 32'h0, 32'h0, 32'h0, 32'h0, "post_rst_read");

    // Input high across reset release gives one rising event
    reset_n = 1'b0;
    in_port = 10'h002;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    read4(2'd3, 32'h2, 32'h0, 32'h2, 32'h2, "release_high");
    read4(2'd0, 32'h2, 32'h2, 32'h2, 32'h2, "release_stable");

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never sampled", sb.size());
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
